// File: rtl/riscv_dcache_pkg.sv
// ============================================================================
//  Module      : riscv_dcache_pkg
//  Description : Shared types and defaults for the data-cache controller:
//                state encoding, geometry defaults and the tag-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_dcache_pkg;

  // Default cache geometry; INDEX must agree with the data array depth.
  localparam int unsigned ADDR_WIDTH_DEF  = 64;
  localparam int unsigned INDEX_DEF       = 12;
  localparam int unsigned BYTE_OFFSET_DEF = 4;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } dcache_state_t;

  // Tag bits are whatever the index and line offset leave of the address.
  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned index_w,
                                            input int unsigned offset_w);
    return addr_w - index_w - offset_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_dcache_if.sv
// ============================================================================
//  Module      : riscv_dcache_if
//  Description : Bundle of the CPU memory-stage, tag-array, data-array and
//                DRAM signals seen by the data-cache controller.
//                master = controller view, slave = surrounding system view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_dcache_if
  import riscv_dcache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned INDEX       = INDEX_DEF,
  parameter int unsigned BYTE_OFFSET = BYTE_OFFSET_DEF
);

  localparam int unsigned TAG = tag_width(ADDR_WIDTH, INDEX, BYTE_OFFSET);

  // CPU memory stage
  logic                  cpu_rden;
  logic                  cpu_wren;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  stall;

  // Tag array (combinational read at the cpu_addr index)
  logic                  tag_valid;
  logic                  tag_dirty;
  logic                  tag_match;
  logic [TAG-1:0]        victim_tag;
  logic                  tag_wren;
  logic                  set_dirty;

  // Data array strobes
  logic                  cache_wren;
  logic                  cache_rden;
  logic                  mem_in;

  // DRAM
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;

  modport master (
    input  cpu_rden, cpu_wren, cpu_addr,
    input  tag_valid, tag_dirty, tag_match, victim_tag,
    input  mem_ready,
    output stall, cache_wren, cache_rden, mem_in,
    output tag_wren, set_dirty,
    output mem_req, mem_we, mem_addr
  );

  modport slave (
    output cpu_rden, cpu_wren, cpu_addr,
    output tag_valid, tag_dirty, tag_match, victim_tag,
    output mem_ready,
    input  stall, cache_wren, cache_rden, mem_in,
    input  tag_wren, set_dirty,
    input  mem_req, mem_we, mem_addr
  );

endinterface

`default_nettype wire

// File: rtl/riscv_dcache_ctrl.sv
// ============================================================================
//  Module      : riscv_dcache_ctrl
//  Description : Controller FSM for a direct-mapped, write-back,
//                write-allocate data cache. Detects hit/miss, stalls the
//                pipeline, writes back a dirty victim, refills the line from
//                DRAM and replays the access.
//                Optional feature macro: DCACHE_PERF_CNT_EN adds the
//                hit_cnt / miss_cnt performance counter outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_dcache_ctrl
  import riscv_dcache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned INDEX       = INDEX_DEF,
  parameter int unsigned BYTE_OFFSET = BYTE_OFFSET_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef DCACHE_PERF_CNT_EN
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt,
`endif
  riscv_dcache_if.master bus
);

  localparam int unsigned TAG = tag_width(ADDR_WIDTH, INDEX, BYTE_OFFSET);

  dcache_state_t         state_q, state_d;

  logic [TAG-1:0]        cpu_tag;
  logic [INDEX-1:0]      cpu_index;
  logic                  req;
  logic                  hit;

  logic                  stall_o;
  logic                  cache_wren_o;
  logic                  cache_rden_o;
  logic                  mem_in_o;
  logic                  tag_wren_o;
  logic                  set_dirty_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;

  assign cpu_tag   = bus.cpu_addr[ADDR_WIDTH-1 -: TAG];
  assign cpu_index = bus.cpu_addr[BYTE_OFFSET +: INDEX];
  // A simultaneous load and store is handled as a store.
  assign req       = bus.cpu_rden | bus.cpu_wren;
  assign hit       = bus.tag_valid & bus.tag_match;

  // State register; reset returns to IDLE from anywhere, abandoning DRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe generation.
  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    cache_wren_o = 1'b0;
    cache_rden_o = 1'b0;
    mem_in_o     = 1'b0;
    tag_wren_o   = 1'b0;
    set_dirty_o  = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (bus.cpu_wren) begin
              cache_wren_o = 1'b1;
              set_dirty_o  = 1'b1;
            end else begin
              cache_rden_o = 1'b1;
            end
          end else begin
            // Miss: freeze the pipeline in the same cycle.
            stall_o = 1'b1;
            state_d = (bus.tag_valid && bus.tag_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        // Data array output provides the victim line to DRAM.
        stall_o      = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        cache_rden_o = 1'b1;
        mem_addr_o   = {bus.victim_tag, cpu_index, {BYTE_OFFSET{1'b0}}};
        if (bus.mem_ready) begin
          state_d = ALLOCATE;
        end
      end

      ALLOCATE: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {cpu_tag, cpu_index, {BYTE_OFFSET{1'b0}}};
        if (bus.mem_ready) begin
          // Refill data is valid this cycle: write the full line and tag.
          cache_wren_o = 1'b1;
          mem_in_o     = 1'b1;
          tag_wren_o   = 1'b1;
          state_d      = UPDATE;
        end
      end

      UPDATE: begin
        // One settle cycle so the replayed access sees the new line.
        stall_o = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is held, whatever the CPU asks.
    if (!rst_n) begin
      stall_o      = 1'b0;
      cache_wren_o = 1'b0;
      cache_rden_o = 1'b0;
      mem_in_o     = 1'b0;
      tag_wren_o   = 1'b0;
      set_dirty_o  = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
    end
  end

  assign bus.stall      = stall_o;
  assign bus.cache_wren = cache_wren_o;
  assign bus.cache_rden = cache_rden_o;
  assign bus.mem_in     = mem_in_o;
  assign bus.tag_wren   = tag_wren_o;
  assign bus.set_dirty  = set_dirty_o;
  assign bus.mem_req    = mem_req_o;
  assign bus.mem_we     = mem_we_o;
  assign bus.mem_addr   = mem_addr_o;

`ifdef DCACHE_PERF_CNT_EN
  logic        replay_q;
  logic        cnt_hit;
  logic        cnt_miss;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The IDLE cycle right after UPDATE is the replay and is not a new decision.
  assign cnt_hit  = (state_q == IDLE) && req && hit && !replay_q;
  assign cnt_miss = (state_q == IDLE) && req && !hit;

  // Hit/miss counters, free-running and wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q <= (state_q == UPDATE);
      if (cnt_hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (cnt_miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
`endif

  // Every state other than IDLE must hold the pipeline.
  a_stall_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> bus.stall);

  // DRAM addresses are always line aligned.
  a_line_align : assert property (@(posedge clk) disable iff (!rst_n)
    bus.mem_addr[BYTE_OFFSET-1:0] == '0);

endmodule

`default_nettype wire

// File: tb/tb_riscv_dcache_ctrl.sv
// ============================================================================
//  Module      : tb_riscv_dcache_ctrl
//  Description : Directed self-checking bench for riscv_dcache_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_dcache_ctrl;

  localparam int unsigned AW = 64;
  localparam int unsigned IW = 12;
  localparam int unsigned BO = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  riscv_dcache_if #(.ADDR_WIDTH(AW), .INDEX(IW), .BYTE_OFFSET(BO)) bus ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  riscv_dcache_ctrl #(.ADDR_WIDTH(AW), .INDEX(IW), .BYTE_OFFSET(BO)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef DCACHE_PERF_CNT_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [63:0] addr,
                       input logic valid, input logic dirty, input logic match,
                       input logic [47:0] vtag, input logic ready);
    bus.cpu_rden   = rd;
    bus.cpu_wren   = wr;
    bus.cpu_addr   = addr;
    bus.tag_valid  = valid;
    bus.tag_dirty  = dirty;
    bus.tag_match  = match;
    bus.victim_tag = vtag;
    bus.mem_ready  = ready;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Clean miss to addr with DRAM answering in the lat-th ALLOCATE cycle,
  // followed by UPDATE and the replay hit.
  task automatic clean_miss(input logic [63:0] addr, input int lat, input string nm);
    int stalls;
    stalls = 0;
    drive(1'b1, 1'b0, addr, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
    @(negedge clk);
    chk({nm, " idle stall"}, bus.stall, 1'b1);
    chk({nm, " idle no req"}, bus.mem_req, 1'b0);
    stalls += int'(bus.stall);
    for (int c = 1; c <= lat; c++) begin
      next_cycle();
      bus.mem_ready = (c == lat);
      @(negedge clk);
      chk({nm, " alloc req"}, bus.mem_req, 1'b1);
      chk({nm, " alloc we"}, bus.mem_we, 1'b0);
      chk({nm, " alloc addr"}, bus.mem_addr, addr & ~64'hF);
      chk({nm, " alloc tag_wren"}, bus.tag_wren, (c == lat));
      chk({nm, " alloc mem_in"}, bus.mem_in, (c == lat));
      chk({nm, " alloc cache_wren"}, bus.cache_wren, (c == lat));
      stalls += int'(bus.stall);
    end
    next_cycle();
    // Tag array now holds the refilled line.
    drive(1'b1, 1'b0, addr, 1'b1, 1'b0, 1'b1, 48'h0, 1'b1);
    @(negedge clk);
    chk({nm, " update stall"}, bus.stall, 1'b1);
    chk({nm, " update quiet"}, {bus.mem_req, bus.tag_wren, bus.cache_wren}, 3'b000);
    stalls += int'(bus.stall);
    next_cycle();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk({nm, " replay stall"}, bus.stall, 1'b0);
    chk({nm, " replay rden"}, bus.cache_rden, 1'b1);
    chk({nm, " stall cycles"}, 64'(stalls), 64'(lat + 2));
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);

    // Reset state, and outputs stay quiet even with a miss presented.
    @(negedge clk);
    chk("rst stall", bus.stall, 1'b0);
    chk("rst mem_req", bus.mem_req, 1'b0);
    chk("rst mem_addr", bus.mem_addr, 64'h0);
    drive(1'b1, 1'b0, 64'h2000, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
    #1;
    chk("rst gated stall", bus.stall, 1'b0);
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
    rst_n = 1'b1;

    // Idle, no request, stray mem_ready: nothing moves.
    next_cycle();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("idle quiet", {bus.stall, bus.cache_rden, bus.cache_wren, bus.mem_req, bus.tag_wren}, 5'b0);
    next_cycle();
    bus.mem_ready = 1'b0;

    // Load hit at 0x1008 in line 0x1000.
    drive(1'b1, 1'b0, 64'h1008, 1'b1, 1'b0, 1'b1, 48'h1, 1'b0);
    @(negedge clk);
    chk("ld hit stall", bus.stall, 1'b0);
    chk("ld hit rden", bus.cache_rden, 1'b1);
    chk("ld hit wren", bus.cache_wren, 1'b0);
    chk("ld hit mem_req", bus.mem_req, 1'b0);

    // Store hit at 0x100F.
    next_cycle();
    drive(1'b0, 1'b1, 64'h100F, 1'b1, 1'b0, 1'b1, 48'h1, 1'b0);
    @(negedge clk);
    chk("st hit stall", bus.stall, 1'b0);
    chk("st hit strobes", {bus.cache_wren, bus.cache_rden, bus.mem_in, bus.set_dirty}, 4'b1001);

    // Load and store together behave as a store.
    next_cycle();
    drive(1'b1, 1'b1, 64'h1004, 1'b1, 1'b1, 1'b1, 48'h1, 1'b0);
    @(negedge clk);
    chk("rd+wr strobes", {bus.cache_wren, bus.cache_rden, bus.set_dirty}, 3'b101);
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);

    // Clean miss, DRAM answers in the third ALLOCATE cycle.
    clean_miss(64'h2000, 3, "clean");

    // Dirty miss: victim tag 0x5 at index 0x200.
    drive(1'b1, 1'b0, 64'h2000, 1'b1, 1'b1, 1'b0, 48'h5, 1'b0);
    @(negedge clk);
    chk("dirty idle stall", bus.stall, 1'b1);
    next_cycle();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("wb req/we/rden", {bus.mem_req, bus.mem_we, bus.cache_rden}, 3'b111);
    chk("wb addr", bus.mem_addr, 64'h52000);
    chk("wb stall", bus.stall, 1'b1);
    next_cycle();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("dirty alloc req/we", {bus.mem_req, bus.mem_we}, 2'b10);
    chk("dirty alloc addr", bus.mem_addr, 64'h2000);
    next_cycle();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("dirty refill", {bus.cache_wren, bus.mem_in, bus.tag_wren, bus.cache_rden}, 4'b1110);
    next_cycle();
    drive(1'b1, 1'b0, 64'h2000, 1'b1, 1'b0, 1'b1, 48'h2, 1'b0);
    @(negedge clk);
    chk("dirty update stall", bus.stall, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("dirty replay stall", bus.stall, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);

    // Request dropped mid-miss: refill still finishes, then back to IDLE.
    drive(1'b1, 1'b0, 64'h3010, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
    next_cycle();
    bus.cpu_rden = 1'b0;
    @(negedge clk);
    chk("drop alloc req", bus.mem_req, 1'b1);
    chk("drop alloc addr", bus.mem_addr, 64'h3010);
    next_cycle();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("drop refill", bus.tag_wren, 1'b1);
    next_cycle();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("drop update stall", bus.stall, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("drop idle", {bus.stall, bus.cache_rden, bus.mem_req}, 3'b000);

    // Reset during ALLOCATE: mem_req and stall drop immediately.
    next_cycle();
    drive(1'b1, 1'b0, 64'h2000, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("pre-rst alloc req", bus.mem_req, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst alloc mem_req", bus.mem_req, 1'b0);
    chk("rst alloc stall", bus.stall, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    // Back in IDLE: the still-missing request stalls but no DRAM request yet.
    chk("post-rst idle", {bus.stall, bus.mem_req}, 2'b10);
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
    bus.mem_ready = 1'b1;
    next_cycle();
    bus.mem_ready = 1'b0;
    next_cycle();
    next_cycle();

`ifdef DCACHE_PERF_CNT_EN
    // Fresh counters: 3 hits and 2 misses, replay hits not counted.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 64'h1000 + 64'(i * 4), 1'b1, 1'b0, 1'b1, 48'h1, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
    clean_miss(64'h4000, 2, "perf1");
    clean_miss(64'h5000, 1, "perf2");
    next_cycle();
    chk("hit_cnt", 64'(hit_cnt), 64'd3);
    chk("miss_cnt", 64'(miss_cnt), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
